neuron_weight_ctrl: RTL and testbench

NEURON_WEIGHT_CTRL -- requirements
Module: neuron_weight_ctrl

---
 rtl/neuron_weight_ctrl.sv | 170 +++++++++++++++++
 tb/tb_neuron_weight_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/neuron_weight_ctrl.sv
// Weight-memory controller for one neuron: captures its weights from the shared
// config bus, then streams read addresses to the MAC for each accepted sample.
module neuron_weight_ctrl #(
  parameter int numWeight    = 3,
  parameter int neuronNo     = 5,
  parameter int layerNo      = 1,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16,
  parameter int pretrained   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  input  logic [31:0]             cfg_layer,
  input  logic [31:0]             cfg_neuron,
  input  logic [dataWidth-1:0]    cfg_data,
  output logic                    cfg_ready,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    wen,
  output logic [addressWidth-1:0] wadd,
  output logic [dataWidth-1:0]    win,
  output logic                    ren,
  output logic [addressWidth-1:0] radd,
  output logic                    mac_valid,
  output logic                    mac_last,
  output logic                    load_done
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam bit PRE    = (pretrained != 0);
  localparam bit SINGLE = (numWeight == 1);
  localparam state_t RST_STATE = PRE ? ST_RUN : ST_LOAD;
  localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(numWeight - 1);
  localparam logic [addressWidth-1:0] ZERO_ADDR = addressWidth'(0);

  function automatic logic [addressWidth-1:0] inc_wrap(input logic [addressWidth-1:0] p);
    if (p == LAST_ADDR) begin
      return ZERO_ADDR;
    end else begin
      return p + addressWidth'(1);
    end
  endfunction

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [addressWidth-1:0] r_wr_ptr;
  logic [addressWidth-1:0] w_wr_ptr_nxt;
  logic [addressWidth-1:0] r_rd_ptr;
  logic [addressWidth-1:0] w_rd_ptr_nxt;
  logic                    r_wen;
  logic                    w_wen_nxt;
  logic [addressWidth-1:0] r_wadd;
  logic [addressWidth-1:0] w_wadd_nxt;
  logic [dataWidth-1:0]    r_win;
  logic [dataWidth-1:0]    w_win_nxt;
  logic                    r_mac_valid;
  logic                    r_mac_last;
  logic                    r_cfg_ready;
  logic                    w_match;
  logic                    w_load_done;
  logic                    w_in_ready;
  logic                    w_accept;

  // A pretrained neuron never claims config words, so they cannot disturb it.
  assign w_match = r_cfg_ready & cfg_valid & ~PRE &
                   (cfg_layer == 32'(layerNo)) & (cfg_neuron == 32'(neuronNo));
  assign w_load_done = (r_state == ST_RUN);
  assign w_in_ready  = w_load_done & ~w_match;
  assign w_accept    = in_valid & w_in_ready & rst_n;

  // Next-state and next register values; a matching word outside LOAD restarts the load.
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_wen_nxt    = 1'b0;
    w_wadd_nxt   = r_wadd;
    w_win_nxt    = r_win;
    case (r_state)
      ST_LOAD: begin
        if (w_match) begin
          w_wen_nxt    = 1'b1;
          w_wadd_nxt   = r_wr_ptr;
          w_win_nxt    = cfg_data;
          w_wr_ptr_nxt = inc_wrap(r_wr_ptr);
          if (r_wr_ptr == LAST_ADDR) begin
            w_state_nxt = ST_FLUSH;
          end else begin
            w_state_nxt = ST_LOAD;
          end
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_FLUSH, ST_RUN: begin
        if (w_match) begin
          w_wen_nxt    = 1'b1;
          w_wadd_nxt   = ZERO_ADDR;
          w_win_nxt    = cfg_data;
          w_rd_ptr_nxt = ZERO_ADDR;
          if (SINGLE) begin
            w_wr_ptr_nxt = ZERO_ADDR;
            w_state_nxt  = ST_FLUSH;
          end else begin
            w_wr_ptr_nxt = addressWidth'(1);
            w_state_nxt  = ST_LOAD;
          end
        end else if (w_accept) begin
          w_rd_ptr_nxt = inc_wrap(r_rd_ptr);
          w_state_nxt  = ST_RUN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = RST_STATE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RST_STATE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pointers, write port and MAC qualifiers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= ZERO_ADDR;
      r_rd_ptr    <= ZERO_ADDR;
      r_wen       <= 1'b0;
      r_wadd      <= ZERO_ADDR;
      r_win       <= {dataWidth{1'b0}};
      r_mac_valid <= 1'b0;
      r_mac_last  <= 1'b0;
      r_cfg_ready <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_wen       <= w_wen_nxt;
      r_wadd      <= w_wadd_nxt;
      r_win       <= w_win_nxt;
      r_mac_valid <= w_accept;
      r_mac_last  <= w_accept & (r_rd_ptr == LAST_ADDR);
      r_cfg_ready <= 1'b1;
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign in_ready  = w_in_ready;
  assign wen       = r_wen;
  assign wadd      = r_wadd;
  assign win       = r_win;
  assign ren       = w_accept;
  assign radd      = r_rd_ptr;
  assign mac_valid = r_mac_valid;
  assign mac_last  = r_mac_last;
  assign load_done = w_load_done;

endmodule

// File: tb/tb_neuron_weight_ctrl.sv
// Directed bench for neuron_weight_ctrl: write and MAC expectations are queued
// when stimulus is driven and checked in the cycle the DUT should produce them.
module tb_neuron_weight_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [31:0] cfg_layer = 32'd0;
  logic [31:0] cfg_neuron = 32'd0;
  logic [15:0] cfg_data = 16'd0;
  logic        in_valid = 1'b0;

  logic        cfg_ready, in_ready, wen, ren, mac_valid, mac_last, load_done;
  logic [9:0]  wadd, radd;
  logic [15:0] win;
  logic        pt_cfg_ready, pt_in_ready, pt_wen, pt_ren, pt_mac_valid, pt_mac_last, pt_load_done;
  logic [9:0]  pt_wadd, pt_radd;
  logic [15:0] pt_win;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct { int cyc; logic [9:0] a; logic [15:0] d; } wr_t;
  typedef struct { int cyc; logic last; } rd_t;
  wr_t wq[$];
  rd_t rq[$];

  always #5 clk = ~clk;

  neuron_weight_ctrl #(.numWeight(3), .neuronNo(5), .layerNo(1), .addressWidth(10),
                       .dataWidth(16), .pretrained(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_layer(cfg_layer),
    .cfg_neuron(cfg_neuron), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .in_valid(in_valid), .in_ready(in_ready), .wen(wen), .wadd(wadd), .win(win),
    .ren(ren), .radd(radd), .mac_valid(mac_valid), .mac_last(mac_last),
    .load_done(load_done)
  );

  neuron_weight_ctrl #(.numWeight(3), .neuronNo(5), .layerNo(1), .addressWidth(10),
                       .dataWidth(16), .pretrained(1)) u_pt (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_layer(cfg_layer),
    .cfg_neuron(cfg_neuron), .cfg_data(cfg_data), .cfg_ready(pt_cfg_ready),
    .in_valid(in_valid), .in_ready(pt_in_ready), .wen(pt_wen), .wadd(pt_wadd), .win(pt_win),
    .ren(pt_ren), .radd(pt_radd), .mac_valid(pt_mac_valid), .mac_last(pt_mac_last),
    .load_done(pt_load_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_due();
    if (wq.size() > 0 && wq[0].cyc == cyc) begin
      chk("wen", {31'd0, wen}, 32'd1);
      chk("wadd", {22'd0, wadd}, {22'd0, wq[0].a});
      chk("win", {16'd0, win}, {16'd0, wq[0].d});
      void'(wq.pop_front());
    end else begin
      chk("wen_idle", {31'd0, wen}, 32'd0);
    end
    if (rq.size() > 0 && rq[0].cyc == cyc) begin
      chk("mac_valid", {31'd0, mac_valid}, 32'd1);
      chk("mac_last", {31'd0, mac_last}, {31'd0, rq[0].last});
      void'(rq.pop_front());
    end else begin
      chk("mac_valid_idle", {31'd0, mac_valid}, 32'd0);
    end
  endtask

  task automatic step(input bit cv, input logic [31:0] neu, input logic [15:0] d,
                      input bit iv, input bit e_ir, input bit e_ld, input bit e_wr,
                      input logic [9:0] e_wadd, input logic [9:0] e_radd);
    bit e_ren;
    e_ren = iv && e_ir;
    cfg_valid  = cv;
    cfg_layer  = 32'd1;
    cfg_neuron = neu;
    cfg_data   = d;
    in_valid   = iv;
    @(negedge clk);
    check_due();
    chk("cfg_ready", {31'd0, cfg_ready}, 32'd1);
    chk("in_ready", {31'd0, in_ready}, {31'd0, e_ir});
    chk("ren", {31'd0, ren}, {31'd0, e_ren});
    if (e_ren) chk("radd", {22'd0, radd}, {22'd0, e_radd});
    chk("load_done", {31'd0, load_done}, {31'd0, e_ld});
    chk("pt_wen", {31'd0, pt_wen}, 32'd0);
    chk("pt_load_done", {31'd0, pt_load_done}, 32'd1);
    if (e_wr) wq.push_back(wr_t'{cyc + 1, e_wadd, d});
    if (e_ren) rq.push_back(rd_t'{cyc + 1, (e_radd == 10'd2)});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("rst_wen", {31'd0, wen}, 32'd0);
    chk("rst_ren", {31'd0, ren}, 32'd0);
    chk("rst_mac_valid", {31'd0, mac_valid}, 32'd0);
    chk("rst_mac_last", {31'd0, mac_last}, 32'd0);
    chk("rst_wadd", {22'd0, wadd}, 32'd0);
    chk("rst_radd", {22'd0, radd}, 32'd0);
    chk("rst_win", {16'd0, win}, 32'd0);
    chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_load_done", {31'd0, load_done}, 32'd0);
    chk("rst_pt_load_done", {31'd0, pt_load_done}, 32'd1);
    chk("rst_pt_wen", {31'd0, pt_wen}, 32'd0);
    wq.delete();
    rq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc += 3;
    chk("pt_in_ready", {31'd0, pt_in_ready}, 32'd1);
  endtask

  initial begin
    do_reset();

    // load with non-matching words before and between the matching ones
    step(1'b1, 32'd4, 16'h0055, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    step(1'b1, 32'd5, 16'h000A, 1'b1, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0);
    step(1'b1, 32'd4, 16'h0066, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    step(1'b1, 32'd5, 16'h000B, 1'b1, 1'b0, 1'b0, 1'b1, 10'd1, 10'd0);
    step(1'b1, 32'd5, 16'h000C, 1'b1, 1'b0, 1'b0, 1'b1, 10'd2, 10'd0);
    step(1'b0, 32'd5, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);

    // stream four samples back to back
    step(1'b0, 32'd5, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
    step(1'b0, 32'd5, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd1);
    step(1'b0, 32'd5, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd2);
    step(1'b0, 32'd5, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0);

    // collision: cfg wins, reload restarts at address 0
    step(1'b1, 32'd5, 16'h0077, 1'b1, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0);
    step(1'b0, 32'd5, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    step(1'b1, 32'd5, 16'h0088, 1'b0, 1'b0, 1'b0, 1'b1, 10'd1, 10'd0);
    step(1'b1, 32'd5, 16'h0099, 1'b0, 1'b0, 1'b0, 1'b1, 10'd2, 10'd0);
    step(1'b0, 32'd5, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    step(1'b0, 32'd5, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
    step(1'b0, 32'd5, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd1);
    step(1'b0, 32'd5, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0);

    // reset after two of three words discards the partial load
    do_reset();
    step(1'b1, 32'd5, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0);
    step(1'b1, 32'd5, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1, 10'd1, 10'd0);
    do_reset();
    step(1'b1, 32'd5, 16'h0011, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0);
    step(1'b1, 32'd5, 16'h0022, 1'b0, 1'b0, 1'b0, 1'b1, 10'd1, 10'd0);
    step(1'b0, 32'd5, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    step(1'b1, 32'd5, 16'h0033, 1'b0, 1'b0, 1'b0, 1'b1, 10'd2, 10'd0);
    step(1'b0, 32'd5, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    step(1'b0, 32'd5, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
    step(1'b0, 32'd5, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
    step(1'b0, 32'd5, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
